// File: rtl/sensor_pkg.sv
// Shared types for the sensor alarm controller.
//   alarm_state_t : alarm FSM state encoding
//   NUM_SENSORS   : width of the sensor vector and of the captured alarm code
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    QUALIFY    = 2'd1,
    REQUEST    = 2'd2,
    WAIT_CLEAR = 2'd3
  } alarm_state_t;

  localparam int NUM_SENSORS = 4;

endpackage

// File: rtl/sensor_alarm_ctrl_if.sv
// Signal bundle between the sensor error detector / supervisor side and the
// alarm controller.
//   error, sensors   : raw, asynchronous to clk
//   ack, clr_cnt     : supervisor controls, synchronous to clk
//   alarm_req        : latched alarm request
//   alarm_code       : sensor snapshot taken when the error was confirmed
//   error_count      : saturating count of confirmed events
//   overflow         : sticky saturation flag
// master = supervisor / stimulus side, slave = sensor_alarm_ctrl.
interface sensor_alarm_ctrl_if #(
  parameter int CNT_WIDTH = 8
);
  import sensor_pkg::*;

  logic                   error;
  logic [NUM_SENSORS-1:0] sensors;
  logic                   ack;
  logic                   clr_cnt;
  logic                   alarm_req;
  logic [NUM_SENSORS-1:0] alarm_code;
  logic [CNT_WIDTH-1:0]   error_count;
  logic                   overflow;

  modport master (
    output error, sensors, ack, clr_cnt,
    input  alarm_req, alarm_code, error_count, overflow
  );

  modport slave (
    input  error, sensors, ack, clr_cnt,
    output alarm_req, alarm_code, error_count, overflow
  );

endinterface

// File: rtl/sensor_sync.sv
// Two-flop synchroniser for a bundle of asynchronous inputs.
//   clk   : destination clock
//   n_rst : asynchronous active-low reset, both stages cleared to 0
//   d     : asynchronous input bundle
//   q     : synchronised output (second stage)
// Bits are synchronised independently; the bundle is not guaranteed to be
// captured coherently on the same edge.
module sensor_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sensor_alarm_ctrl.sv
// Consumer side of the sensor error flag: synchronises error/sensors,
// debounces the error, raises an alarm request held until acknowledged,
// captures the active sensors and keeps a saturating event count.
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   bus   : sensor_alarm_ctrl_if slave (error, sensors, ack, clr_cnt in;
//           alarm_req, alarm_code, error_count, overflow out)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no error seen; waiting for synchronised error
// QUALIFY    | error high, counting consecutive high cycles
// REQUEST    | error confirmed; alarm_req high until ack
// WAIT_CLEAR | acknowledged; waiting for error to drop before re-arming
module sensor_alarm_ctrl
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  sensor_alarm_ctrl_if.slave  bus
);

  localparam int                   DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0]     DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [NUM_SENSORS:0]   sync_q;
  logic                   err_s;
  logic [NUM_SENSORS-1:0] sens_s;

  alarm_state_t           state, state_nxt;
  logic [DEB_W-1:0]       deb_cnt, deb_nxt;
  logic                   confirm;

  logic                   alarm_req_q;
  logic [NUM_SENSORS-1:0] alarm_code_q;
  logic [CNT_WIDTH-1:0]   error_count_q;
  logic                   overflow_q;

  sensor_sync #(.WIDTH(NUM_SENSORS + 1)) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     ({bus.error, bus.sensors}),
    .q     (sync_q)
  );

  assign err_s  = sync_q[NUM_SENSORS];
  assign sens_s = sync_q[NUM_SENSORS-1:0];

  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    confirm   = 1'b0;
    unique case (state)
      IDLE: begin
        if (err_s) begin
          state_nxt = QUALIFY;
          deb_nxt   = DEB_W'(1);
        end else begin
          deb_nxt   = '0;
        end
      end
      QUALIFY: begin
        if (!err_s) begin
          state_nxt = IDLE;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = REQUEST;
          deb_nxt   = '0;
          confirm   = 1'b1;
        end else begin
          deb_nxt   = deb_cnt + DEB_W'(1);
        end
      end
      REQUEST: begin
        if (bus.ack) state_nxt = WAIT_CLEAR;
      end
      WAIT_CLEAR: begin
        // a persistent error must drop before the block re-arms
        if (!err_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        deb_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      alarm_req_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      // registered from next state so alarm_req is high exactly in REQUEST
      alarm_req_q <= (state_nxt == REQUEST);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      alarm_code_q <= '0;
    end else if (confirm) begin
      alarm_code_q <= sens_s;
    end
  end

  // clear wins over saturation; an event on the clearing edge still counts once
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      error_count_q <= '0;
      overflow_q    <= 1'b0;
    end else if (bus.clr_cnt) begin
      error_count_q <= confirm ? CNT_WIDTH'(1) : '0;
      overflow_q    <= 1'b0;
    end else if (confirm) begin
      if (error_count_q == CNT_MAX) begin
        overflow_q    <= 1'b1;
      end else begin
        error_count_q <= error_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.alarm_req   = alarm_req_q;
  assign bus.alarm_code  = alarm_code_q;
  assign bus.error_count = error_count_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
module tb_sensor_alarm_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       error = 1'b0;
  logic [3:0] sensors = 4'b0000;
  logic       ack = 1'b0;
  logic       clr_cnt = 1'b0;

  always #5 clk = ~clk;

  sensor_alarm_ctrl_if #(.CNT_WIDTH(8)) bus8 ();
  sensor_alarm_ctrl_if #(.CNT_WIDTH(2)) bus2 ();

  assign bus8.error   = error;
  assign bus8.sensors = sensors;
  assign bus8.ack     = ack;
  assign bus8.clr_cnt = clr_cnt;
  assign bus2.error   = error;
  assign bus2.sensors = sensors;
  assign bus2.ack     = ack;
  assign bus2.clr_cnt = clr_cnt;

  sensor_alarm_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .bus(bus8)
  );
  sensor_alarm_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .bus(bus2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: inputs reach the decision logic two edges late; an
  // alarm fires once D consecutive delayed-high samples are seen while armed,
  // stays pending until ack, then the block is disarmed until error drops.
  logic       m_e1 = 0, m_e2 = 0;
  logic [3:0] m_s1 = 0, m_s2 = 0;
  int         m_run = 0;
  int         m_phase = 0;    // 0 armed, 1 alarm pending, 2 disarmed
  logic       m_req = 0;
  logic [3:0] m_code = 0;
  int         m_cnt8 = 0, m_cnt2 = 0;
  logic       m_ovf8 = 0, m_ovf2 = 0;
  bit         m_ev;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_e1 = 0; m_e2 = 0; m_s1 = 0; m_s2 = 0;
      m_run = 0; m_phase = 0; m_req = 0; m_code = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_ovf8 = 0; m_ovf2 = 0;
    end else begin
      m_ev = 0;
      if (m_phase == 0) begin
        if (m_e2) begin
          m_run++;
          if (m_run == D) begin
            m_ev = 1; m_phase = 1; m_code = m_s2; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (m_phase == 1) begin
        if (ack) m_phase = 2;
      end else begin
        if (!m_e2) m_phase = 0;
      end
      m_req = (m_phase == 1);
      if (clr_cnt) begin
        m_cnt8 = m_ev ? 1 : 0; m_ovf8 = 0;
        m_cnt2 = m_ev ? 1 : 0; m_ovf2 = 0;
      end else if (m_ev) begin
        if (m_cnt8 == 255) m_ovf8 = 1; else m_cnt8++;
        if (m_cnt2 == 3)   m_ovf2 = 1; else m_cnt2++;
      end
      m_e2 = m_e1; m_e1 = error;
      m_s2 = m_s1; m_s1 = sensors;
    end
  end

  always @(negedge clk) begin
    chk("req8",  32'(bus8.alarm_req),   32'(m_req));
    chk("code8", 32'(bus8.alarm_code),  32'(m_code));
    chk("cnt8",  32'(bus8.error_count), 32'(m_cnt8));
    chk("ovf8",  32'(bus8.overflow),    32'(m_ovf8));
    chk("req2",  32'(bus2.alarm_req),   32'(m_req));
    chk("code2", 32'(bus2.alarm_code),  32'(m_code));
    chk("cnt2",  32'(bus2.error_count), 32'(m_cnt2));
    chk("ovf2",  32'(bus2.overflow),    32'(m_ovf2));
  end

  task automatic wait_req(input int maxc);
    int c;
    c = 0;
    while (bus8.alarm_req !== 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("req_timeout", 32'(bus8.alarm_req), 32'd1);
  endtask

  task automatic do_event(input logic [3:0] s);
    error = 1'b1; sensors = s;
    wait_req(12);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; error = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int hi;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req",  32'(bus8.alarm_req),   32'd0);
    chk("rst_code", 32'(bus8.alarm_code),  32'd0);
    chk("rst_cnt",  32'(bus8.error_count), 32'd0);
    chk("rst_ovf",  32'(bus8.overflow),    32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // glitch: 3 high, 1 low, 3 high never confirms
    error = 1'b1;
    repeat (3) @(negedge clk);
    error = 1'b0;
    @(negedge clk);
    error = 1'b1;
    repeat (3) @(negedge clk);
    error = 1'b0;
    repeat (6) @(negedge clk);
    chk("glitch_req", 32'(bus8.alarm_req),   32'd0);
    chk("glitch_cnt", 32'(bus8.error_count), 32'd0);

    // latency: request after the 6th edge with error high
    error = 1'b1; sensors = 4'b0110;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("latency", 32'(bus8.alarm_req), (i >= 6) ? 32'd1 : 32'd0);
    end
    chk("code_0110", 32'(bus8.alarm_code),  32'b0110);
    chk("cnt_1",     32'(bus8.error_count), 32'd1);
    sensors = 4'b1001;
    repeat (2) @(negedge clk);
    chk("code_hold", 32'(bus8.alarm_code), 32'b0110);
    chk("req_hold",  32'(bus8.alarm_req),  32'd1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_drop", 32'(bus8.alarm_req), 32'd0);
    repeat (20) @(negedge clk);
    chk("no_realarm", 32'(bus8.alarm_req),   32'd0);
    chk("cnt_still1", 32'(bus8.error_count), 32'd1);
    error = 1'b0;
    repeat (4) @(negedge clk);

    // ack held high throughout: one-cycle request
    ack = 1'b1;
    repeat (3) @(negedge clk);
    error = 1'b1; sensors = 4'b0011;
    hi = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.alarm_req === 1'b1) hi++;
    end
    chk("ack_held_len", 32'(hi), 32'd1);
    error = 1'b0;
    repeat (4) @(negedge clk);
    ack = 1'b0;
    chk("cnt_2", 32'(bus2.error_count), 32'd2);

    // saturation on the 2-bit counter
    do_event(4'b0101);
    chk("sat_cnt3", 32'(bus2.error_count), 32'd3);
    chk("sat_ovf0", 32'(bus2.overflow),    32'd0);
    do_event(4'b1010);
    chk("sat_cnt3b", 32'(bus2.error_count), 32'd3);
    chk("sat_ovf1",  32'(bus2.overflow),    32'd1);
    chk("cnt8_4",    32'(bus8.error_count), 32'd4);

    // clear on the confirming edge
    error = 1'b1; sensors = 4'b1111;
    repeat (5) @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_ev_req", 32'(bus2.alarm_req),   32'd1);
    chk("clr_ev_cnt", 32'(bus2.error_count), 32'd1);
    chk("clr_ev_ovf", 32'(bus2.overflow),    32'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; error = 1'b0;
    repeat (4) @(negedge clk);

    // clear alone
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_cnt2", 32'(bus2.error_count), 32'd0);
    chk("clr_ovf2", 32'(bus2.overflow),    32'd0);
    chk("clr_cnt8", 32'(bus8.error_count), 32'd0);
    chk("clr_code", 32'(bus8.alarm_code),  32'b1111);

    // reset in the middle of a request
    error = 1'b1; sensors = 4'b1100;
    wait_req(12);
    chk("pre_rst_cnt", 32'(bus8.error_count), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_req",  32'(bus8.alarm_req),   32'd0);
    chk("mid_rst_cnt",  32'(bus8.error_count), 32'd0);
    chk("mid_rst_code", 32'(bus8.alarm_code),  32'd0);
    error = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_req", 32'(bus8.alarm_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
